// File: rtl/ddr2_test_seq.sv
// ddr2_test_seq: write/read-back traffic sequencer for the DDR2 MIG user port.
// Writes an incrementing word pattern over a linear range, then reads the range
// back and checks every returned word.
// Optional build macro DDR2_TEST_CHK_EN: compiles in the read-data compare and
// the saturating error counter. Without it, returned words are only counted.
module ddr2_test_seq #(
  parameter int          NUM_WORDS = 2048,
  parameter logic [30:0] BASE_ADDR = 31'd0,
  parameter int          TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        phy_init_done,
  input  logic        app_af_afull,
  input  logic        app_wdf_afull,
  input  logic        rd_data_valid,
  input  logic [31:0] rd_data_fifo_out,
  output logic        app_af_wren,
  output logic [2:0]  app_af_cmd,
  output logic [30:0] app_af_addr,
  output logic        app_wdf_wren,
  output logic [31:0] app_wdf_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_CMD  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0]  CMD_WR  = 3'b000;
  localparam logic [2:0]  CMD_RD  = 3'b001;
  localparam logic [31:0] LAST_WR = 32'(NUM_WORDS - 1);
  localparam logic [31:0] LAST_RC = 32'(NUM_WORDS / 2 - 1);
  localparam logic [31:0] N_WORDS = 32'(NUM_WORDS);
  localparam logic [31:0] TMO     = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic        init_q, init_d;
  logic [31:0] wr_idx_q, wr_idx_d;
  logic [31:0] rc_idx_q, rc_idx_d;
  logic [31:0] rd_idx_q, rd_idx_d;
  logic [31:0] idle_q, idle_d;

  logic        app_af_wren_q, app_af_wren_d;
  logic [2:0]  app_af_cmd_q, app_af_cmd_d;
  logic [30:0] app_af_addr_q, app_af_addr_d;
  logic        app_wdf_wren_q, app_wdf_wren_d;
  logic [31:0] app_wdf_data_q, app_wdf_data_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_count_q, err_count_d;

  logic        wr_go;
  logic        rc_go;
  logic        rd_phase;
  logic        rd_take;

`ifndef DDR2_TEST_CHK_EN
  // Returned data is not inspected in this build; only its strobe is counted.
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data_fifo_out;
`endif

  // Next-state, issue and read-check logic; everything lands in output flops.
  always_comb begin
    state_d        = state_q;
    init_d         = init_q | phy_init_done;
    wr_idx_d       = wr_idx_q;
    rc_idx_d       = rc_idx_q;
    rd_idx_d       = rd_idx_q;
    idle_d         = idle_q;
    app_af_wren_d  = 1'b0;
    app_af_cmd_d   = app_af_cmd_q;
    app_af_addr_d  = app_af_addr_q;
    app_wdf_wren_d = 1'b0;
    app_wdf_data_d = app_wdf_data_q;
    timeout_d      = timeout_q;
    err_count_d    = err_count_q;
    wr_go          = 1'b0;
    rc_go          = 1'b0;

    rd_phase = (state_q == RD_CMD) || (state_q == RD_WAIT);
    rd_take  = rd_phase && rd_data_valid && (rd_idx_q < N_WORDS);

    // The IDLE->WR transition already issues beat 0 so the first strobe
    // is visible in the same cycle the FSM shows WR.
    case (state_q)
      IDLE:    if (init_q) begin
                 state_d = WR;
                 wr_go   = !app_af_afull && !app_wdf_afull;
               end
      WR:      wr_go = !app_af_afull && !app_wdf_afull;
      RD_CMD:  rc_go = !app_af_afull;
      default: ;
    endcase

    if (wr_go) begin
      app_wdf_wren_d = 1'b1;
      app_wdf_data_d = wr_idx_q;
      if (!wr_idx_q[0]) begin
        app_af_wren_d = 1'b1;
        app_af_cmd_d  = CMD_WR;
        app_af_addr_d = BASE_ADDR + {wr_idx_q[29:0], 1'b0};
      end
      if (wr_idx_q == LAST_WR) begin
        state_d = RD_CMD;
        idle_d  = '0;
      end else begin
        wr_idx_d = wr_idx_q + 32'd1;
      end
    end

    if (rc_go) begin
      app_af_wren_d = 1'b1;
      app_af_cmd_d  = CMD_RD;
      app_af_addr_d = BASE_ADDR + {rc_idx_q[28:0], 2'b00};
      if (rc_idx_q == LAST_RC) state_d = RD_WAIT;
      else                     rc_idx_d = rc_idx_q + 32'd1;
    end

    if (rd_phase) begin
      if (rd_data_valid)      idle_d = '0;
      else if (idle_q != '1)  idle_d = idle_q + 32'd1;
    end

    if (rd_take) begin
      rd_idx_d = rd_idx_q + 32'd1;
`ifdef DDR2_TEST_CHK_EN
      if ((rd_data_fifo_out != rd_idx_q) && (err_count_q != 16'hFFFF))
        err_count_d = err_count_q + 16'd1;
`endif
    end

    if (state_q == RD_WAIT) begin
      if (rd_idx_q == N_WORDS) begin
        state_d = DONE;
      end else if (idle_d >= TMO) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
    end

    done_d = (state_d == DONE);
    pass_d = done_d && (err_count_d == 16'd0) && !timeout_d;
  end

  // Single state register for FSM, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      init_q         <= 1'b0;
      wr_idx_q       <= '0;
      rc_idx_q       <= '0;
      rd_idx_q       <= '0;
      idle_q         <= '0;
      app_af_wren_q  <= 1'b0;
      app_af_cmd_q   <= '0;
      app_af_addr_q  <= '0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_data_q <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      init_q         <= init_d;
      wr_idx_q       <= wr_idx_d;
      rc_idx_q       <= rc_idx_d;
      rd_idx_q       <= rd_idx_d;
      idle_q         <= idle_d;
      app_af_wren_q  <= app_af_wren_d;
      app_af_cmd_q   <= app_af_cmd_d;
      app_af_addr_q  <= app_af_addr_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_data_q <= app_wdf_data_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      err_count_q    <= err_count_d;
    end
  end

  assign app_af_wren  = app_af_wren_q;
  assign app_af_cmd   = app_af_cmd_q;
  assign app_af_addr  = app_af_addr_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_data = app_wdf_data_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_ddr2_test_seq.sv
// tb_ddr2_test_seq: scoreboard bench for ddr2_test_seq with a small MIG memory
// model (stores written words, returns two words per read command).
module tb_ddr2_test_seq;

  localparam int          NW   = 8;
  localparam int          TMO  = 20;
  localparam logic [30:0] BASE = 31'd0;
  localparam int          LAT  = 4;

  logic        clk;
  logic        reset_n;
  logic        phy_init_done;
  logic        app_af_afull;
  logic        app_wdf_afull;
  logic        rd_data_valid;
  logic [31:0] rd_data_fifo_out;
  logic        app_af_wren;
  logic [2:0]  app_af_cmd;
  logic [30:0] app_af_addr;
  logic        app_wdf_wren;
  logic [31:0] app_wdf_data;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_count;

  ddr2_test_seq #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .phy_init_done    (phy_init_done),
    .app_af_afull     (app_af_afull),
    .app_wdf_afull    (app_wdf_afull),
    .rd_data_valid    (rd_data_valid),
    .rd_data_fifo_out (rd_data_fifo_out),
    .app_af_wren      (app_af_wren),
    .app_af_cmd       (app_af_cmd),
    .app_af_addr      (app_af_addr),
    .app_wdf_wren     (app_wdf_wren),
    .app_wdf_data     (app_wdf_data),
    .done             (done),
    .pass             (pass),
    .timeout          (timeout),
    .err_count        (err_count)
  );

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } ret_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;
  int          exp_w[$];
  int          exp_r[$];
  ret_t        retq[$];
  logic [31:0] mem[int];
  int          wbeats, rcmds, rwords;
  int          first_wr_cyc, last_valid_edge;
  bit          corrupt_en, drop_en, extra_en;
  logic [30:0] cur_waddr;
  logic        af_s, wdf_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter and the flag values the DUT sampled on this edge.
  initial begin
    af_s  = 1'b0;
    wdf_s = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      af_s  = app_af_afull;
      wdf_s = app_wdf_afull;
    end
  end

  // Scoreboard + memory model: checks strobes, drives read returns.
  initial begin
    int e;
    int r;
    ret_t t;
    rd_data_valid    = 1'b0;
    rd_data_fifo_out = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_data_valid    = 1'b0;
        rd_data_fifo_out = '0;
      end else begin
        if (app_wdf_wren) begin
          if (exp_w.size() == 0) begin
            check("wr_extra", 1, 0);
          end else begin
            e = exp_w.pop_front();
            check("wr_data", app_wdf_data, e);
            check("wr_af_wren", {31'd0, app_af_wren}, (e % 2 == 0) ? 1 : 0);
            if (e % 2 == 0) begin
              check("wr_addr", {1'b0, app_af_addr}, {1'b0, 31'(BASE + 31'(2 * e))});
              check("wr_cmd", {29'd0, app_af_cmd}, 0);
              cur_waddr = app_af_addr;
            end
            mem[int'(cur_waddr) + (e % 2)] = app_wdf_data;
          end
          if (wbeats == 0) first_wr_cyc = cyc;
          wbeats++;
        end else if (app_af_wren) begin
          if (exp_r.size() == 0) begin
            check("rd_extra", 1, 0);
          end else begin
            r = exp_r.pop_front();
            check("rd_cmd", {29'd0, app_af_cmd}, 1);
            check("rd_addr", {1'b0, app_af_addr}, {1'b0, 31'(BASE + 31'(4 * r))});
            for (int j = 0; j < 2; j++) begin
              t.data = mem.exists(int'(app_af_addr) + j) ? mem[int'(app_af_addr) + j] : 32'hBAD0_BAD0;
              t.rdy  = cyc + LAT;
              if (corrupt_en && (rwords == 3 || rwords == 5)) t.data = t.data ^ 32'd1;
              if (!(drop_en && rwords >= NW - 2)) retq.push_back(t);
              if (extra_en && rwords == NW - 1) begin
                t.data = 32'hDEAD_BEEF;
                retq.push_back(t);
              end
              rwords++;
            end
          end
          rcmds++;
        end
        if (wdf_s) check("bp_wdf_wren", {31'd0, app_wdf_wren}, 0);
        if (af_s)  check("bp_af_wren", {31'd0, app_af_wren}, 0);
        if (retq.size() > 0 && retq[0].rdy <= cyc) begin
          t = retq.pop_front();
          rd_data_valid    = 1'b1;
          rd_data_fifo_out = t.data;
          last_valid_edge  = cyc + 1;
        end else begin
          rd_data_valid    = 1'b0;
          rd_data_fifo_out = '0;
        end
      end
    end
  end

  task automatic load_expect();
    exp_w.delete();
    exp_r.delete();
    retq.delete();
    mem.delete();
    wbeats = 0;
    rcmds  = 0;
    rwords = 0;
    first_wr_cyc = -1;
    for (int i = 0; i < NW; i++)     exp_w.push_back(i);
    for (int i = 0; i < NW / 2; i++) exp_r.push_back(i);
  endtask

  task automatic start_test();
    @(negedge clk); #1;
    reset_n       = 1'b0;
    phy_init_done = 1'b0;
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    corrupt_en    = 1'b0;
    drop_en       = 1'b0;
    extra_en      = 1'b0;
    load_expect();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_until_done(input bit bp);
    int n = 0;
    int bpw = 0;
    int bpa = 0;
    while (!done && n < 400) begin
      @(negedge clk); #1;
      n++;
      if (bp) begin
        app_wdf_afull = (wbeats >= 3 && bpw < 10);
        if (app_wdf_afull) bpw++;
        app_af_afull = (rcmds >= 1 && bpa < 5);
        if (app_af_afull) bpa++;
      end
    end
    app_wdf_afull = 1'b0;
    app_af_afull  = 1'b0;
    check("done", {31'd0, done}, 1);
    if (bp) begin
      check("bp_wdf_cycles", bpw, 10);
      check("bp_af_cycles", bpa, 5);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_af_wren"}, {31'd0, app_af_wren}, 0);
    check({pfx, "_af_cmd"}, {29'd0, app_af_cmd}, 0);
    check({pfx, "_af_addr"}, {1'b0, app_af_addr}, 0);
    check({pfx, "_wdf_wren"}, {31'd0, app_wdf_wren}, 0);
    check({pfx, "_wdf_data"}, app_wdf_data, 0);
    check({pfx, "_done"}, {31'd0, done}, 0);
    check({pfx, "_pass"}, {31'd0, pass}, 0);
    check({pfx, "_timeout"}, {31'd0, timeout}, 0);
    check({pfx, "_err"}, {16'd0, err_count}, 0);
  endtask

  task automatic check_end(input logic exp_pass, input logic exp_tmo, input int exp_err);
    check("pass", {31'd0, pass}, {31'd0, exp_pass});
    check("timeout", {31'd0, timeout}, {31'd0, exp_tmo});
    check("err_count", {16'd0, err_count}, exp_err);
    check("wr_beats", wbeats, NW);
    check("rd_cmds", rcmds, NW / 2);
    check("wr_left", exp_w.size(), 0);
    check("rd_left", exp_r.size(), 0);
  endtask

  initial begin
    int c0;
    int n;
    ret_t t;
    reset_n       = 1'b1;
    phy_init_done = 1'b0;
    app_af_afull  = 1'b0;
    app_wdf_afull = 1'b0;
    corrupt_en    = 1'b0;
    drop_en       = 1'b0;
    extra_en      = 1'b0;
    load_expect();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("rst");
    reset_n = 1'b1;

    // Minimal run, with a stray valid in IDLE and an extra word after the last one.
    start_test();
    extra_en = 1'b1;
    t.data = 32'h1234_5678;
    t.rdy  = 0;
    retq.push_back(t);
    repeat (3) @(negedge clk);
    #1;
    c0 = cyc;
    phy_init_done = 1'b1;
    run_until_done(1'b0);
    check("first_wr_latency", first_wr_cyc - c0, 2);
    check_end(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("done_sticky", {31'd0, done}, 1);
    check("done_no_af", {31'd0, app_af_wren}, 0);
    check("done_no_wdf", {31'd0, app_wdf_wren}, 0);

    // Backpressure on both FIFOs.
    start_test();
    phy_init_done = 1'b1;
    run_until_done(1'b1);
    check_end(1'b1, 1'b0, 0);

    // Corrupted read words 3 and 5.
    start_test();
    corrupt_en = 1'b1;
    phy_init_done = 1'b1;
    run_until_done(1'b0);
`ifdef DDR2_TEST_CHK_EN
    check_end(1'b0, 1'b0, 2);
`else
    check_end(1'b1, 1'b0, 0);
`endif

    // Last two read words never return.
    start_test();
    drop_en = 1'b1;
    phy_init_done = 1'b1;
    run_until_done(1'b0);
    check("tmo_idle_cycles", cyc - last_valid_edge, TMO);
    check_end(1'b0, 1'b1, 0);

    // Reset in the middle of the write phase.
    start_test();
    phy_init_done = 1'b1;
    n = 0;
    while (wbeats < 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_wbeats", wbeats, 3);
    @(posedge clk); #2;
    check("pre_rst_data", app_wdf_data, 3);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    load_expect();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    run_until_done(1'b0);
    check_end(1'b1, 1'b0, 0);

    // phy_init_done high for a single cycle.
    start_test();
    phy_init_done = 1'b1;
    @(negedge clk); #1;
    phy_init_done = 1'b0;
    run_until_done(1'b0);
    check_end(1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
